// File: rtl/adc_reader_pkg.sv
// Shared register map and bit positions for the ADC sample reader.
package adc_reader_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_THRESH = 2'd3
  } reg_addr_e;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_FLUSH_BIT   = 1;
  localparam int CTRL_OVF_CLR_BIT = 2;

  localparam int STATUS_OVF_BIT   = 8;
  localparam int STATUS_FULL_BIT  = 7;
  localparam int STATUS_EMPTY_BIT = 6;

  localparam int DATA_VALID_BIT   = 31;

  // The block owns one 16-byte window of the Wishbone space.
  function automatic logic addr_match(input logic [31:0] adr, input logic [31:0] base);
    return adr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous FIFO holding captured ADC words; flush empties it in one edge.
module adc_sample_fifo #(
  parameter  int DATA_W = 10,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when a pop frees a slot on the same edge.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage has no reset; stale words are unreachable because level gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/adc_sample_reader.sv
// Wishbone responder that buffers ADC conversion words and raises a level/overflow interrupt.
module adc_sample_reader
  import adc_reader_pkg::*;
#(
  parameter int          DATA_W    = 10,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              adc_valid_i,
  output logic              irq_o
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             ack_q;
  logic [31:0]      dat_q, dat_d;
  logic             en_q, en_d;
  logic [LVL_W-1:0] thresh_q, thresh_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;

  logic              req, wr, rd;
  reg_addr_e         reg_sel;
  logic              pop, push, flush, ovf_clr, push_try, overflow;
  logic [DATA_W-1:0] fifo_rdata;
  logic [LVL_W-1:0]  level;
  logic              full, empty;
  logic [31:0]       rdata;

  // Upper data/select lanes and byte offset bits carry no meaning for this block.
  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i[3:1], wbs_dat_i, wbs_adr_i[1:0]};

  assign req     = wbs_cyc_i & wbs_stb_i & addr_match(wbs_adr_i, BASE_ADDR) & ~ack_q;
  assign reg_sel = reg_addr_e'(wbs_adr_i[3:2]);
  assign wr      = req & wbs_we_i & wbs_sel_i[0];
  assign rd      = req & ~wbs_we_i;

  assign pop      = rd & (reg_sel == REG_DATA) & ~empty;
  assign flush    = wr & (reg_sel == REG_CTRL) & wbs_dat_i[CTRL_FLUSH_BIT];
  assign ovf_clr  = wr & (reg_sel == REG_CTRL) & wbs_dat_i[CTRL_OVF_CLR_BIT];
  assign push_try = adc_valid_i & en_q;
  assign push     = push_try & (~full | pop);
  assign overflow = push_try & full & ~pop;

  adc_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (adc_data_i),
    .rdata_o (fifo_rdata),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_DATA: begin
        rdata[DATA_VALID_BIT] = ~empty;
        rdata[DATA_W-1:0]     = empty ? '0 : fifo_rdata;
      end
      REG_STATUS: begin
        rdata[STATUS_OVF_BIT]   = ovf_q;
        rdata[STATUS_FULL_BIT]  = full;
        rdata[STATUS_EMPTY_BIT] = empty;
        rdata[LVL_W-1:0]        = level;
      end
      REG_CTRL:   rdata[CTRL_EN_BIT] = en_q;
      REG_THRESH: rdata[LVL_W-1:0]   = thresh_q;
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    dat_d    = rd ? rdata : '0;
    en_d     = en_q;
    thresh_d = thresh_q;
    if (wr && reg_sel == REG_CTRL)   en_d     = wbs_dat_i[CTRL_EN_BIT];
    if (wr && reg_sel == REG_THRESH) thresh_d = wbs_dat_i[LVL_W-1:0];
    // A fresh overflow outranks a clear issued on the same edge.
    if (overflow)     ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
    irq_d = ((thresh_q != '0) && (level >= thresh_q)) | ovf_q;
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      en_q     <= 1'b0;
      thresh_q <= LVL_W'(DEPTH);
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ack_q    <= req;
      dat_q    <= dat_d;
      en_q     <= en_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_adc_sample_reader.sv
// Directed self-checking bench for adc_sample_reader (DATA_W=10, DEPTH=8).
module tb_adc_sample_reader;

  localparam logic [31:0] A_DATA   = 32'h3000_0000;
  localparam logic [31:0] A_STATUS = 32'h3000_0004;
  localparam logic [31:0] A_CTRL   = 32'h3000_0008;
  localparam logic [31:0] A_THRESH = 32'h3000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [9:0]  adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_sample_reader #(
    .DATA_W    (10),
    .DEPTH     (8),
    .BASE_ADDR (32'h3000_0000)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .adc_data_i  (adc_data),
    .adc_valid_i (adc_valid),
    .irq_o       (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 8);
    check({tag, "_ack"}, {31'b0, ack}, 32'h1);
  endtask

  task automatic wb_read(input logic [31:0] a, input string tag, input logic [31:0] exp);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = a; wdat = '0;
    wait_ack(tag);
    check(tag, rdat, exp);
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = s; adr = a; wdat = d;
    wait_ack("write");
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic strobe(input logic [9:0] d);
    @(negedge clk);
    adc_data = d; adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  // DATA read whose request edge coincides with an ADC strobe.
  task automatic read_with_push(input logic [9:0] d, input string tag, input logic [31:0] exp);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = A_DATA;
    adc_data = d; adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
    check({tag, "_ack"}, {31'b0, ack}, 32'h1);
    check(tag, rdat, exp);
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    wb_read(A_STATUS, "rst_status", 32'h0000_0040);
    @(negedge clk);
    check("dat_idle_zero", rdat, 32'h0);
    wb_read(A_DATA,   "rst_data",   32'h0000_0000);
    wb_read(A_THRESH, "rst_thresh", 32'h0000_0008);
    check("rst_irq2", {31'b0, irq}, 32'h0);

    // Three samples read back in order
    wb_write(A_CTRL, 32'h1, 4'hF);
    strobe(10'h001); strobe(10'h2AA); strobe(10'h3FF);
    wb_read(A_STATUS, "three_status", 32'h0000_0003);
    wb_read(A_DATA, "three_d0", 32'h8000_0001);
    wb_read(A_DATA, "three_d1", 32'h8000_02AA);
    wb_read(A_DATA, "three_d2", 32'h8000_03FF);
    wb_read(A_DATA, "three_empty", 32'h0000_0000);

    // Nine strobes into an 8-deep FIFO -> overflow
    for (int i = 0; i < 9; i++) strobe(10'(10'h010 + i));
    wb_read(A_STATUS, "ovf_status", 32'h0000_0188);
    check("ovf_irq", {31'b0, irq}, 32'h1);
    for (int i = 0; i < 8; i++) wb_read(A_DATA, $sformatf("ovf_d%0d", i), 32'h8000_0010 + i);
    wb_read(A_STATUS, "ovf_sticky", 32'h0000_0140);
    wb_write(A_CTRL, 32'h5, 4'hF);
    wb_read(A_STATUS, "ovf_cleared", 32'h0000_0040);
    check("ovf_irq_clear", {31'b0, irq}, 32'h0);

    // Full FIFO with push on the same edge as a pop
    for (int i = 0; i < 8; i++) strobe(10'(10'h020 + i));
    wb_read(A_STATUS, "full_status", 32'h0000_0088);
    read_with_push(10'h028, "full_pop_push", 32'h8000_0020);
    wb_read(A_STATUS, "full_after", 32'h0000_0088);
    for (int i = 0; i < 8; i++) wb_read(A_DATA, $sformatf("full_d%0d", i), 32'h8000_0021 + i);

    // Empty FIFO with push on the same edge as a pop
    read_with_push(10'h155, "empty_pop_push", 32'h0000_0000);
    wb_read(A_STATUS, "empty_after", 32'h0000_0001);
    wb_read(A_DATA, "empty_d0", 32'h8000_0155);

    // Threshold interrupt timing; writes without sel[0] are ignored
    wb_write(A_THRESH, 32'h3, 4'hF);
    wb_write(A_THRESH, 32'h5, 4'hE);
    wb_read(A_THRESH, "thresh_sel", 32'h0000_0003);
    strobe(10'h001); strobe(10'h002);
    check("thr_irq_lvl2", {31'b0, irq}, 32'h0);
    strobe(10'h003);
    check("thr_irq_same", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("thr_irq_set", {31'b0, irq}, 32'h1);
    wb_read(A_DATA, "thr_pop", 32'h8000_0001);
    check("thr_irq_hold", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("thr_irq_drop", {31'b0, irq}, 32'h0);
    wb_write(A_CTRL, 32'h3, 4'hF);
    wb_read(A_STATUS, "flush_status", 32'h0000_0040);
    wb_read(A_CTRL, "flush_ctrl", 32'h0000_0001);

    // Capture disabled
    wb_write(A_CTRL, 32'h0, 4'hF);
    strobe(10'h111); strobe(10'h222);
    wb_read(A_STATUS, "en0_status", 32'h0000_0040);

    // Non-matching address gets no ack
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    check("miss_no_ack", {31'b0, seen}, 32'h0);
    cyc = 1'b0; stb = 1'b0;

    // Reset while a request is pending
    wb_write(A_CTRL, 32'h1, 4'hF);
    strobe(10'h0AA); strobe(10'h0BB);
    wb_read(A_STATUS, "pre_rst_status", 32'h0000_0002);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STATUS; rst = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    if (ack) seen = 1'b1;
    check("rst_mid_no_ack", {31'b0, seen}, 32'h0);
    wb_read(A_STATUS, "rst_mid_status", 32'h0000_0040);
    wb_read(A_CTRL,   "rst_mid_ctrl",   32'h0000_0000);
    wb_read(A_THRESH, "rst_mid_thresh", 32'h0000_0008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
